// File: rtl/rx_deframer.sv
// Packet deframer: turns a symbol stream into length-prefixed payload bytes
// followed by an XOR checksum, with abort and boundary-detector handshake.
module rx_deframer #(
  parameter int LEN_WIDTH = 8,
  parameter int MAX_LEN   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_enable,
  input  logic       BPSK,
  input  logic       BD_flag,
  input  logic       BD_sgn,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       chk_ok,
  output logic       len_err,
  output logic       pkt_abort,
  output logic       disassert_BD
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // One counter serves both the length field and the 8-bit byte phases.
  localparam int CNT_W = (LEN_WIDTH > 8) ? $clog2(LEN_WIDTH) : 3;

  logic [2:0]           state_reg;
  logic [CNT_W-1:0]     bit_cnt_reg;
  logic [LEN_WIDTH-2:0] len_shift_reg;
  logic [6:0]           byte_shift_reg;
  logic [LEN_WIDTH-1:0] byte_cnt_reg;
  logic [7:0]           acc_reg;
  logic                 armed_reg;

  logic                 b;
  logic [LEN_WIDTH-1:0] len_full;
  logic [7:0]           byte_full;
  logic                 len_legal;
  logic                 last_len_bit;
  logic                 last_byte_bit;

  assign b             = BPSK ^ BD_sgn;
  assign len_full      = {len_shift_reg, b};
  assign byte_full     = {byte_shift_reg, b};
  assign len_legal     = (len_full != '0) && (32'(len_full) <= MAX_LEN);
  assign last_len_bit  = (bit_cnt_reg == CNT_W'(LEN_WIDTH - 1));
  assign last_byte_bit = (bit_cnt_reg == CNT_W'(7));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      bit_cnt_reg    <= '0;
      len_shift_reg  <= '0;
      byte_shift_reg <= '0;
      byte_cnt_reg   <= '0;
      acc_reg        <= '0;
      armed_reg      <= 1'b1;
      byte_data      <= '0;
      byte_valid     <= 1'b0;
      pkt_start      <= 1'b0;
      pkt_end        <= 1'b0;
      chk_ok         <= 1'b0;
      len_err        <= 1'b0;
      pkt_abort      <= 1'b0;
      disassert_BD   <= 1'b0;
    end else begin
      byte_valid   <= 1'b0;
      pkt_start    <= 1'b0;
      pkt_end      <= 1'b0;
      len_err      <= 1'b0;
      pkt_abort    <= 1'b0;
      disassert_BD <= 1'b0;
      if (clk_enable) begin
        case (state_reg)
          S_IDLE: begin
            if (!BD_flag) begin
              armed_reg <= 1'b1;
            end else if (armed_reg) begin
              len_shift_reg <= (LEN_WIDTH - 1)'(b);
              bit_cnt_reg   <= CNT_W'(1);
              state_reg     <= S_LEN;
            end
          end
          S_LEN, S_PAYLOAD, S_CHK: begin
            if (!BD_flag) begin
              // Boundary lost: drop everything collected so far.
              pkt_abort      <= 1'b1;
              state_reg      <= S_IDLE;
              armed_reg      <= 1'b1;
              bit_cnt_reg    <= '0;
              len_shift_reg  <= '0;
              byte_shift_reg <= '0;
              byte_cnt_reg   <= '0;
            end else if (state_reg == S_LEN) begin
              len_shift_reg <= len_full[LEN_WIDTH-2:0];
              bit_cnt_reg   <= bit_cnt_reg + CNT_W'(1);
              if (last_len_bit) begin
                bit_cnt_reg <= '0;
                if (len_legal) begin
                  pkt_start    <= 1'b1;
                  chk_ok       <= 1'b0;
                  acc_reg      <= '0;
                  byte_cnt_reg <= len_full;
                  state_reg    <= S_PAYLOAD;
                end else begin
                  len_err   <= 1'b1;
                  state_reg <= S_DONE;
                end
              end
            end else begin
              byte_shift_reg <= byte_full[6:0];
              bit_cnt_reg    <= bit_cnt_reg + CNT_W'(1);
              if (last_byte_bit) begin
                bit_cnt_reg <= '0;
                if (state_reg == S_PAYLOAD) begin
                  byte_data  <= byte_full;
                  byte_valid <= 1'b1;
                  acc_reg    <= acc_reg ^ byte_full;
                  if (byte_cnt_reg != '0) begin
                    byte_cnt_reg <= byte_cnt_reg - LEN_WIDTH'(1);
                  end
                  if (byte_cnt_reg <= LEN_WIDTH'(1)) begin
                    state_reg <= S_CHK;
                  end
                end else begin
                  // Checksum byte is consumed here and never shown on byte_data.
                  chk_ok    <= (byte_full == acc_reg);
                  pkt_end   <= 1'b1;
                  state_reg <= S_DONE;
                end
              end
            end
          end
          S_DONE: begin
            disassert_BD <= 1'b1;
            armed_reg    <= 1'b0;
            state_reg    <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule
